// File: rtl/mul_pipe.sv
// Three-stage pipelined WIDTH x WIDTH multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready, tag and flush.
// Optional MUL_PIPE_FULL_PRODUCT_EN adds the registered full 2*WIDTH product on out_product.
module mul_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
`ifdef MUL_PIPE_FULL_PRODUCT_EN
  output logic [2*WIDTH-1:0] out_product,
`endif
  output logic               busy
);

  localparam int H    = WIDTH / 2;
  localparam int LL_W = 2 * H;
  localparam int PP_W = 2 * H + 2;
  localparam int LO_W = 3 * H + 4;
  localparam int P_W  = 2 * WIDTH + 2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  // Upper operand half, sign-extended by one bit only for a signed operand.
  function automatic logic signed [H:0] hi_half(input logic [WIDTH-1:0] x, input logic sgn);
    return {sgn & x[WIDTH-1], x[WIDTH-1:H]};
  endfunction

  function automatic logic [WIDTH-1:0] sel_half(input logic [2*WIDTH-1:0] p, input logic [1:0] op);
    return (op == OP_MUL) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  logic                     adv, accept, a_sgn, b_sgn;
  logic signed [H:0]        a_lo, a_hi, b_lo, b_hi;
  logic [2*WIDTH-1:0]       prod_w;

  logic [LL_W-1:0]          ll_p0_d, ll_p0_q;
  logic signed [PP_W-1:0]   lh_p0_d, lh_p0_q, hl_p0_d, hl_p0_q, hh_p0_d, hh_p0_q;
  logic [1:0]               op_p0_d, op_p0_q;
  logic [TAG_W-1:0]         tag_p0_d, tag_p0_q;
  logic                     vld_p0_d, vld_p0_q;

  logic signed [LO_W-1:0]   low_p1_d, low_p1_q;
  logic signed [PP_W-1:0]   hh_p1_d, hh_p1_q;
  logic [1:0]               op_p1_d, op_p1_q;
  logic [TAG_W-1:0]         tag_p1_d, tag_p1_q;
  logic                     vld_p1_d, vld_p1_q;

  logic [WIDTH-1:0]         out_result_d, out_result_q;
  logic [TAG_W-1:0]         out_tag_d, out_tag_q;
  logic                     vld_p2_d, vld_p2_q;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
  logic [2*WIDTH-1:0]       out_product_d, out_product_q;
`endif

  always_comb begin
    adv      = !vld_p2_q | out_ready;
    in_ready = adv & !flush;
    accept   = in_valid & in_ready;
    a_sgn    = (in_op == OP_MULH) | (in_op == OP_MULHSU);
    b_sgn    = (in_op == OP_MULH);
    a_lo     = {1'b0, in_a[H-1:0]};
    b_lo     = {1'b0, in_b[H-1:0]};
    a_hi     = hi_half(in_a, a_sgn);
    b_hi     = hi_half(in_b, b_sgn);
    prod_w   = (2*WIDTH)'(P_W'(low_p1_q) + (P_W'(hh_p1_q) <<< WIDTH));

    ll_p0_d      = ll_p0_q;
    lh_p0_d      = lh_p0_q;
    hl_p0_d      = hl_p0_q;
    hh_p0_d      = hh_p0_q;
    op_p0_d      = op_p0_q;
    tag_p0_d     = tag_p0_q;
    low_p1_d     = low_p1_q;
    hh_p1_d      = hh_p1_q;
    op_p1_d      = op_p1_q;
    tag_p1_d     = tag_p1_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
    out_product_d = out_product_q;
`endif

    if (adv) begin
      // p0: partial products
      ll_p0_d  = LL_W'(in_a[H-1:0]) * LL_W'(in_b[H-1:0]);
      lh_p0_d  = PP_W'(a_lo) * PP_W'(b_hi);
      hl_p0_d  = PP_W'(a_hi) * PP_W'(b_lo);
      hh_p0_d  = PP_W'(a_hi) * PP_W'(b_hi);
      op_p0_d  = in_op;
      tag_p0_d = in_tag;
      // p1: low partial sum
      low_p1_d = LO_W'(signed'({1'b0, ll_p0_q})) + (LO_W'(lh_p0_q) <<< H)
               + (LO_W'(hl_p0_q) <<< H);
      hh_p1_d  = hh_p0_q;
      op_p1_d  = op_p0_q;
      tag_p1_d = tag_p0_q;
      // p2: final product and half select
      out_result_d = sel_half(prod_w, op_p1_q);
      out_tag_d    = tag_p1_q;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
      out_product_d = prod_w;
`endif
    end

    vld_p0_d = flush ? 1'b0 : (adv ? accept   : vld_p0_q);
    vld_p1_d = flush ? 1'b0 : (adv ? vld_p0_q : vld_p1_q);
    vld_p2_d = flush ? 1'b0 : (adv ? vld_p1_q : vld_p2_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
      out_product_q <= '0;
`endif
    end else begin
      vld_p0_q     <= vld_p0_d;
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
      out_product_q <= out_product_d;
`endif
    end
  end

  // Intermediate datapath needs no reset; validity is tracked by vld_pN.
  always_ff @(posedge clk) begin
    ll_p0_q  <= ll_p0_d;
    lh_p0_q  <= lh_p0_d;
    hl_p0_q  <= hl_p0_d;
    hh_p0_q  <= hh_p0_d;
    op_p0_q  <= op_p0_d;
    tag_p0_q <= tag_p0_d;
    low_p1_q <= low_p1_d;
    hh_p1_q  <= hh_p1_d;
    op_p1_q  <= op_p1_d;
    tag_p1_q <= tag_p1_d;
  end

  assign out_valid  = vld_p2_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = vld_p0_q | vld_p1_q | vld_p2_q;
`ifdef MUL_PIPE_FULL_PRODUCT_EN
  assign out_product = out_product_q;
`endif

endmodule
